// File: rtl/wb_mem_pkg.sv
// Shared types and constants for the parametrised Wishbone memory slave.
package wb_mem_pkg;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam int unsigned MAX_WAIT = 15;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

endpackage

// File: rtl/wb_mem_array.sv
// DEPTH x DATA_W storage with a byte-enable write port and a registered read port.
module wb_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write; storage itself is not reset (the init sweep fills it).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  // Read register doubles as the bus rdata register; holds until the next read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/wb_mem_slave_p.sv
// Wishbone-classic scratch RAM slave with wait states, range error and init sweep.
module wb_mem_slave_p
  import wb_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [7:0]  INIT_VAL    = 8'h11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cyc,
  input  logic                stb,
  input  logic                we,
  input  logic [DATA_W/8-1:0] sel,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ack,
  output logic                err,
  output logic                init_done
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   ptr;

  logic               req_c;
  logic               in_range_c;
  logic               access_c;
  logic               arr_we_c;
  logic               arr_re_c;
  logic [IDX_W-1:0]   arr_addr_c;
  logic [NB-1:0]      arr_be_c;
  logic [DATA_W-1:0]  arr_wdata_c;

  // Request decode and the single access edge at the end of the wait phase.
  assign req_c      = cyc & stb;
  assign in_range_c = (32'(addr) < DEPTH);
  assign access_c   = (state == WAIT) && req_c && (cnt == '0);

  // Memory port steering: init sweep owns the write port until it completes.
  always_comb begin
    arr_we_c    = 1'b0;
    arr_re_c    = 1'b0;
    arr_addr_c  = IDX_W'(addr);
    arr_be_c    = sel;
    arr_wdata_c = wdata;
    if (state == INIT) begin
      arr_we_c    = rst_n;
      arr_addr_c  = ptr;
      arr_be_c    = '1;
      arr_wdata_c = {NB{INIT_VAL}};
    end else if (access_c) begin
      arr_we_c = rst_n & we;
      arr_re_c = ~we;
    end
  end

  // Control FSM with wait counter, init pointer and registered ack/err/init_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      ack       <= 1'b0;
      err       <= 1'b0;
      init_done <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        INIT: begin
          ptr <= ptr + IDX_W'(1);
          if (ptr == IDX_W'(DEPTH - 1)) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (req_c) begin
            if (!in_range_c) begin
              err   <= 1'b1;
              state <= ERR;
            end else begin
              cnt   <= CNT_W'(WAIT_CYCLES);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req_c) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            ack   <= 1'b1;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  wb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (arr_we_c),
    .wr_addr (arr_addr_c),
    .wr_be   (arr_be_c),
    .wr_data (arr_wdata_c),
    .rd_en   (arr_re_c),
    .rd_addr (arr_addr_c),
    .rd_data (rdata)
  );

endmodule

// File: tb/tb_wb_mem_slave_p.sv
// Randomised self-checking bench for wb_mem_slave_p against a word-array model.
module tb_wb_mem_slave_p;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 9;
  localparam int unsigned DEPTH       = 256;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int unsigned NB          = DATA_W / 8;
  localparam logic [DATA_W-1:0] INIT_WORD = 32'h1111_1111;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cyc;
  logic              stb;
  logic              we;
  logic [NB-1:0]     sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              init_done;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] model_rdata;

  always #5 clk = ~clk;

  wb_mem_slave_p #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES),
    .INIT_VAL    (8'h11)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cyc       (cyc),
    .stb       (stb),
    .we        (we),
    .sel       (sel),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ack       (ack),
    .err       (err),
    .init_done (init_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] nw,
                                                   input logic [NB-1:0] s);
    logic [DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT_WORD;
    model_rdata = '0;
  endtask

  // Count cycles from reset release to init_done; requests in this window must be ignored.
  task automatic wait_init();
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (n < DEPTH + 8 && !init_done) begin
      @(negedge clk);
      n++;
      if (ack || err) bad++;
      cyc  = (n < DEPTH - 4);
      stb  = (n < DEPTH - 4);
      we   = 1'b0;
      addr = (n[0]) ? 9'd300 : 9'd3;
    end
    cyc = 1'b0;
    stb = 1'b0;
    check_eq("init_cycles", 64'(n), 64'(DEPTH));
    check_eq("init_no_resp", 64'(bad), 64'd0);
  endtask

  // One bus transfer; hold>0 drops the request after that many edges (abort).
  task automatic xfer(input logic w, input logic [ADDR_W-1:0] a, input logic [NB-1:0] s,
                      input logic [DATA_W-1:0] d, input int hold);
    bit in_range;
    int n;
    int bad;
    bit got;
    in_range = (int'(a) < DEPTH);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; addr = a; wdata = d;
    if (hold > 0 && in_range) begin
      bad = 0;
      for (int k = 1; k <= WAIT_CYCLES + 3; k++) begin
        @(negedge clk);
        if (ack || err) bad++;
        if (k == hold) begin
          cyc = 1'b0;
          stb = 1'b0;
        end
      end
      check_eq("abort_no_resp", 64'(bad), 64'd0);
      check_eq("abort_rdata", 64'(rdata), 64'(model_rdata));
      return;
    end
    n   = 0;
    got = 1'b0;
    while (n < WAIT_CYCLES + 10 && !got) begin
      @(negedge clk);
      n++;
      if (ack || err) got = 1'b1;
    end
    if (!got) begin
      check_eq("resp_timeout", 64'(n), 64'(WAIT_CYCLES + 2));
    end else begin
      check_eq("ack_err_both", 64'(ack & err), 64'd0);
      if (in_range) begin
        check_eq("ack", 64'(ack), 64'd1);
        check_eq("ack_latency", 64'(n), 64'(WAIT_CYCLES + 2));
        if (w) model_mem[a] = lane_merge(model_mem[a], d, s);
        else   model_rdata  = model_mem[a];
      end else begin
        check_eq("err", 64'(err), 64'd1);
        check_eq("err_latency", 64'(n), 64'd1);
      end
      check_eq("rdata", 64'(rdata), 64'(model_rdata));
    end
    cyc = 1'b0;
    stb = 1'b0;
    @(negedge clk);
    check_eq("pulse_end", 64'({ack, err}), 64'd0);
  endtask

  initial begin
    int hold;
    logic [ADDR_W-1:0] ra;
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ack", 64'(ack), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    check_eq("rst_init_done", 64'(init_done), 64'd0);
    rst_n = 1'b1;
    model_reset();
    wait_init();

    xfer(1'b0, 9'd0, 4'hF, '0, 0);
    check_eq("init_word", 64'(rdata), 64'h1111_1111);

    xfer(1'b1, 9'd5, 4'b1111, 32'hDEAD_BEEF, 0);
    xfer(1'b0, 9'd5, 4'b0000, '0, 0);
    check_eq("full_write", 64'(rdata), 64'hDEAD_BEEF);

    xfer(1'b1, 9'd5, 4'b0001, 32'h0000_00AA, 0);
    xfer(1'b0, 9'd5, 4'b1111, '0, 0);
    check_eq("lane_write", 64'(rdata), 64'hDEAD_BEAA);

    xfer(1'b1, 9'd5, 4'b0000, 32'h1234_5678, 0);
    xfer(1'b0, 9'd5, 4'b1111, '0, 0);
    check_eq("sel_zero", 64'(rdata), 64'hDEAD_BEAA);

    xfer(1'b0, 9'd300, 4'hF, '0, 0);
    xfer(1'b1, 9'd256, 4'hF, 32'hFFFF_FFFF, 0);
    xfer(1'b0, 9'd255, 4'hF, '0, 0);

    xfer(1'b1, 9'd7, 4'hF, 32'hCAFE_F00D, 2);
    xfer(1'b0, 9'd7, 4'hF, '0, 0);
    check_eq("abort_mem", 64'(rdata), 64'h1111_1111);

    // Reset in the middle of a write's wait phase.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; addr = 9'd9; wdata = 32'h5555_AAAA;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check_eq("midrst_ack", 64'(ack), 64'd0);
    check_eq("midrst_rdata", 64'(rdata), 64'd0);
    check_eq("midrst_init_done", 64'(init_done), 64'd0);
    rst_n = 1'b1;
    model_reset();
    wait_init();
    xfer(1'b0, 9'd9, 4'hF, '0, 0);
    xfer(1'b0, 9'd5, 4'hF, '0, 0);
    check_eq("reinit_word", 64'(rdata), 64'h1111_1111);

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 3) != 0) ra = ADDR_W'($urandom_range(0, 15));
      else                           ra = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, WAIT_CYCLES + 1)) : 0;
      xfer(1'($urandom_range(0, 1)), ra, NB'($urandom), DATA_W'($urandom), hold);
    end
    for (int i = 0; i < 16; i++) xfer(1'b0, ADDR_W'(i), 4'hF, '0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
